// File: rtl/pc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ctrl_if
//  Purpose  : Bundles the request and response signals between the PC
//             sequencer and its neighbours: hazard unit, EX branch resolution,
//             CSR trap logic, PC register and IF/ID flush controls.
//  Modports : master - the driver of requests; it observes the sequencer outputs
//             slave  - pc_ctrl itself
//  Signals  : pc_i, imem_ready_i, stall_i, br_taken_i, br_target_i, trap_i,
//             mtvec_i, halt_i (towards pc_ctrl); pc_next_o, flush_if_o,
//             flush_id_o, halted_o, misalign_o, redirect_cnt_o (from pc_ctrl)
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_ctrl_if #(
    parameter int X_LEN = 32
);
    logic [X_LEN-1:0] pc_i;
    logic             imem_ready_i;
    logic             stall_i;
    logic             br_taken_i;
    logic [X_LEN-1:0] br_target_i;
    logic             trap_i;
    logic [X_LEN-1:0] mtvec_i;
    logic             halt_i;
    logic [X_LEN-1:0] pc_next_o;
    logic             flush_if_o;
    logic             flush_id_o;
    logic             halted_o;
    logic             misalign_o;
    logic [31:0]      redirect_cnt_o;

    modport master (
        output pc_i, imem_ready_i, stall_i, br_taken_i, br_target_i,
               trap_i, mtvec_i, halt_i,
        input  pc_next_o, flush_if_o, flush_id_o, halted_o, misalign_o,
               redirect_cnt_o
    );

    modport slave (
        input  pc_i, imem_ready_i, stall_i, br_taken_i, br_target_i,
               trap_i, mtvec_i, halt_i,
        output pc_next_o, flush_if_o, flush_id_o, halted_o, misalign_o,
               redirect_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ctrl
//  Purpose  : Next-PC sequencer and redirect controller. It selects the
//             sequential PC, the EX branch target or the trap vector. It holds
//             the PC on a stall or on fetch backpressure, and it latches
//             redirects while fetch is blocked. It also drives the IF/ID flush
//             controls and a count of applied redirects.
//  Ports    : clk_i   - clock, rising edge
//             rst_n_i - synchronous active-low reset
//             bus     - pc_ctrl_if.slave (all request/response signals)
//  Options  : PC_ALIGN_CHECK_EN - flag a misaligned branch target on
//             misalign_o and redirect to mtvec_i. When this option is not
//             defined, the low target bits are cleared instead.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_ctrl #(
    parameter int               X_LEN      = 32,
    parameter logic [X_LEN-1:0] RESET_VEC  = '0,
    parameter int               ILEN_BYTES = 4
) (
    input  wire         clk_i,
    input  wire         rst_n_i,
    pc_ctrl_if.slave    bus
);
    localparam logic [X_LEN-1:0] C_INC        = X_LEN'(ILEN_BYTES);
    localparam logic [X_LEN-1:0] C_ALIGN_MASK = X_LEN'(3);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [X_LEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [31:0]      redirect_cnt_q, redirect_cnt_d;

    logic [X_LEN-1:0] w_pc_next;
    logic             w_flush_if;
    logic             w_flush_id;
    logic             w_halted;
    logic             w_misalign;
    logic             w_redir;
    logic [X_LEN-1:0] w_redir_tgt;
    logic [X_LEN-1:0] w_br_tgt;
    logic             w_br_misaligned;

`ifdef PC_ALIGN_CHECK_EN
    assign w_br_tgt        = bus.br_target_i;
    assign w_br_misaligned = |(bus.br_target_i & C_ALIGN_MASK);
`else
    // The low bits are cleared so that the target stays instruction aligned.
    assign w_br_tgt        = bus.br_target_i & ~C_ALIGN_MASK;
    assign w_br_misaligned = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        pend_tgt_d     = pend_tgt_q;
        redirect_cnt_d = redirect_cnt_q;
        w_pc_next      = bus.pc_i;
        w_flush_if     = 1'b0;
        w_flush_id     = 1'b0;
        w_halted       = 1'b0;
        w_misalign     = 1'b0;
        w_redir        = 1'b0;
        w_redir_tgt    = bus.mtvec_i;

        unique case (state_q)
            ST_RUN: begin
                if (bus.trap_i) begin
                    w_redir = 1'b1;
                end else if (bus.br_taken_i) begin
                    w_redir = 1'b1;
                    // A misaligned target becomes a trap to mtvec_i.
                    if (w_br_misaligned) begin
                        w_misalign = 1'b1;
                    end else begin
                        w_redir_tgt = w_br_tgt;
                    end
                end else if (bus.halt_i) begin
                    state_d = ST_HALT;
                end else if (!bus.stall_i && bus.imem_ready_i) begin
                    w_pc_next = bus.pc_i + C_INC;
                end
            end
            ST_PEND: begin
                // The instruction in IF is wrong-path until the redirect lands.
                // A same-cycle trap replaces the pending target.
                w_flush_if = 1'b1;
                if (bus.trap_i) begin
                    pend_tgt_d = bus.mtvec_i;
                end
                if (bus.imem_ready_i) begin
                    w_pc_next      = bus.trap_i ? bus.mtvec_i : pend_tgt_q;
                    redirect_cnt_d = redirect_cnt_q + 32'd1;
                    state_d        = ST_RUN;
                end
            end
            ST_HALT: begin
                w_halted = 1'b1;
                if (bus.trap_i) begin
                    w_redir = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Shared redirect handling for RUN and HALT. The redirect is applied
        // now when fetch accepts the request. Otherwise it is parked in PEND.
        if (w_redir) begin
            w_flush_if = 1'b1;
            w_flush_id = 1'b1;
            if (bus.imem_ready_i) begin
                w_pc_next      = w_redir_tgt;
                redirect_cnt_d = redirect_cnt_q + 32'd1;
                state_d        = ST_RUN;
            end else begin
                pend_tgt_d = w_redir_tgt;
                state_d    = ST_PEND;
            end
        end

        // Reset takes precedence over every input in the same cycle.
        if (!rst_n_i) begin
            w_pc_next  = RESET_VEC;
            w_flush_if = 1'b0;
            w_flush_id = 1'b0;
            w_halted   = 1'b0;
            w_misalign = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_RUN;
            pend_tgt_q     <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            pend_tgt_q     <= pend_tgt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign bus.pc_next_o      = w_pc_next;
    assign bus.flush_if_o     = w_flush_if;
    assign bus.flush_id_o     = w_flush_id;
    assign bus.halted_o       = w_halted;
    assign bus.misalign_o     = w_misalign;
    assign bus.redirect_cnt_o = redirect_cnt_q;
endmodule
`default_nettype wire
